// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (IF)
// and load/store (MEM). At most one access is granted per cycle. Read data and
// acknowledges return one cycle after the grant. The data port has priority,
// but a fetch that keeps losing eventually wins.
// Optional feature macro: ARB_STATS_EN enables the conflict-cycle counter on
// stat_conf. When the macro is undefined, stat_conf is tied to zero.
module mem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3,
  parameter int STARVE_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic [31:0]       stat_conf
);

  // The state names the port whose access is completing this cycle.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_FLIGHT = 2'd1,
    DM_FLIGHT = 2'd2
  } state_t;

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state, state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                elig_if, elig_dm;
  logic                grant_if, grant_dm;

  // State register. A synchronous reset drops any access that is in flight.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // values from before the edge, regardless of the order of the blocks.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Eligibility, grant selection, memory drive and next-state logic.
  // NOTE: each output is given a default first, so no path through this block
  // leaves a variable unassigned. This prevents latch inference.
  always_comb begin
    elig_if   = 1'b0;
    elig_dm   = 1'b0;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = if_addr;
    mem_wdata = dm_wdata;
    state_nxt = IDLE;

    // A port cannot be granted in the cycle its own valid pulses. In that
    // cycle the requester is still presenting the old address.
    elig_if = if_req && (state != IF_FLIGHT);
    elig_dm = dm_req && (state != DM_FLIGHT);

    if (elig_if && (!elig_dm || starve_cnt == STARVE_LIM)) grant_if = 1'b1;
    else if (elig_dm)                                      grant_dm = 1'b1;

    if (grant_dm) begin
      mem_addr = dm_addr;
      // A store that lines up with reset must not reach the memory.
      mem_we   = dm_we && !reset;
    end

    if (reset)         state_nxt = IDLE;
    else if (grant_if) state_nxt = IF_FLIGHT;
    else if (grant_dm) state_nxt = DM_FLIGHT;
  end

  // Completion pulses and read-data passthrough, one cycle after the grant.
  always_comb begin
    if_valid = (state == IF_FLIGHT) && !reset;
    dm_valid = (state == DM_FLIGHT) && !reset;
    if_rdata = mem_rdata;
    dm_rdata = mem_rdata;
    stall_f  = if_req && !if_valid;
    stall_m  = dm_req && !dm_valid;
  end

  // Count the arbitrations a pending fetch has lost. The count saturates at
  // the limit and clears when the fetch wins or the fetch request is dropped.
  always_ff @(posedge clk) begin
    if (reset || !if_req || grant_if) starve_cnt <= '0;
    else if (elig_if && grant_dm && starve_cnt != STARVE_LIM)
      starve_cnt <= starve_cnt + 1'b1;
  end

`ifdef ARB_STATS_EN
  // Conflict counter: counts every cycle in which both ports were eligible.
  always_ff @(posedge clk) begin
    if (reset)                 stat_conf <= 32'd0;
    else if (elig_if && elig_dm) stat_conf <= stat_conf + 32'd1;
  end
`else
  assign stat_conf = 32'd0;
`endif

endmodule
